// File: rtl/midi_note_rx_if.sv
// Note-event handshake between the MIDI receiver (master) and its consumer (slave).
// The head event fields are valid whenever evt_valid is high.
interface midi_note_rx_if;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_on;
  logic [3:0] evt_channel;
  logic [6:0] evt_note;
  logic [6:0] evt_velocity;

  modport master (output evt_valid, evt_on, evt_channel, evt_note, evt_velocity,
                  input  evt_ready);
  modport slave  (input  evt_valid, evt_on, evt_channel, evt_note, evt_velocity,
                  output evt_ready);
endinterface

// File: rtl/midi_note_rx.sv
// MIDI receiver: oversampled UART framing, running-status parser with channel filter,
// and a first-word-fall-through FIFO of decoded Note On/Off events.
module midi_note_rx #(
  parameter int CLKS_PER_BIT = 3200,
  parameter int FIFO_DEPTH   = 4,
  parameter int OMNI         = 1,
  parameter int CHANNEL      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          midi_in,
  output logic                          rx_led,
  midi_note_rx_if.master                evt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          framing_err,
  output logic                          overflow
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_e;

  logic [1:0]    sync_q, sync_d;
  logic          line_prev_q, line_prev_d;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_stb_q, byte_stb_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    status_q, status_d;
  logic          rs_ok_q, rs_ok_d;
  logic          dcnt_q, dcnt_d;
  logic [6:0]    data0_q, data0_d;
  logic [18:0]   mem_q [FIFO_DEPTH];
  logic [18:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  logic        line;
  logic        ev;
  logic [18:0] ev_word;
  logic        pop, push, full;

  assign line = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], midi_in};
    line_prev_d = line;
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    byte_stb_d  = 1'b0;
    ferr_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Edge-triggered arming also makes us wait for a high line after a framing error.
        cnt_d = '0;
        if (line_prev_q && !line) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = line ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d      = '0;
          state_d    = S_IDLE;
          byte_stb_d = line;
          ferr_d     = !line;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic one_byte, is_note, chan_ok, is_on;
  assign one_byte = (status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD);
  assign is_note  = (status_q[7:5] == 3'b100);
  assign chan_ok  = (OMNI != 0) || (status_q[3:0] == 4'(CHANNEL));
  assign is_on    = status_q[4] && (shift_q[6:0] != 7'd0);

  always_comb begin
    status_d = status_q;
    rs_ok_d  = rs_ok_q;
    dcnt_d   = dcnt_q;
    data0_d  = data0_q;
    ev       = 1'b0;
    ev_word  = '0;
    if (ferr_q) begin
      dcnt_d = 1'b0;
    end else if (byte_stb_q && shift_q[7:3] != 5'b11111) begin
      if (shift_q[7:4] == 4'hF) begin
        rs_ok_d = 1'b0;
        dcnt_d  = 1'b0;
      end else if (shift_q[7]) begin
        status_d = shift_q;
        rs_ok_d  = 1'b1;
        dcnt_d   = 1'b0;
      end else if (rs_ok_q) begin
        if (!dcnt_q) begin
          data0_d = shift_q[6:0];
          dcnt_d  = !one_byte;
        end else begin
          dcnt_d = 1'b0;
          if (is_note && chan_ok) begin
            ev      = 1'b1;
            ev_word = {is_on, status_q[3:0], data0_q, shift_q[6:0]};
          end
        end
      end
    end
  end

  assign full = (count_q == FULL);
  assign pop  = (count_q != '0) && evt.evt_ready;
  assign push = ev && (!full || pop);

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ev && full && !pop;
    if (push) begin
      mem_d[wr_q] = ev_word;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b11;
      line_prev_q <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      byte_stb_q  <= 1'b0;
      ferr_q      <= 1'b0;
      status_q    <= '0;
      rs_ok_q     <= 1'b0;
      dcnt_q      <= 1'b0;
      data0_q     <= '0;
      mem_q       <= '{default: '0};
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      line_prev_q <= line_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      byte_stb_q  <= byte_stb_d;
      ferr_q      <= ferr_d;
      status_q    <= status_d;
      rs_ok_q     <= rs_ok_d;
      dcnt_q      <= dcnt_d;
      data0_q     <= data0_d;
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  assign rx_led         = ~line;
  assign evt.evt_valid  = (count_q != '0);
  assign {evt.evt_on, evt.evt_channel, evt.evt_note, evt.evt_velocity} = mem_q[rd_q];
  assign fifo_count     = count_q;
  assign framing_err    = ferr_q;
  assign overflow       = ovf_q;
endmodule

// File: tb/tb_midi_note_rx.sv
// Bench for midi_note_rx: two instances on one MIDI line (omni, and channel-2 filtered),
// checked against a message-level model of expected note events.
module tb_midi_note_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic midi = 1'b1;
  logic ready = 1'b0;
  logic rx_led_a, rx_led_b;
  logic ferr[2];
  logic ovf[2];
  logic [2:0] cnt[2];
  logic valid[2];
  logic [18:0] head[2];

  midi_note_rx_if if_a();
  midi_note_rx_if if_b();
  assign if_a.evt_ready = ready;
  assign if_b.evt_ready = ready;
  assign valid[0] = if_a.evt_valid;
  assign valid[1] = if_b.evt_valid;
  assign head[0]  = {if_a.evt_on, if_a.evt_channel, if_a.evt_note, if_a.evt_velocity};
  assign head[1]  = {if_b.evt_on, if_b.evt_channel, if_b.evt_note, if_b.evt_velocity};

  midi_note_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .OMNI(1), .CHANNEL(0)) dut_a (
    .clk(clk), .rst(rst), .midi_in(midi), .rx_led(rx_led_a), .evt(if_a),
    .fifo_count(cnt[0]), .framing_err(ferr[0]), .overflow(ovf[0]));
  midi_note_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .OMNI(0), .CHANNEL(2)) dut_b (
    .clk(clk), .rst(rst), .midi_in(midi), .rx_led(rx_led_b), .evt(if_b),
    .fifo_count(cnt[1]), .framing_err(ferr[1]), .overflow(ovf[1]));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ferr_seen[2] = '{0, 0};
  int ovf_seen[2]  = '{0, 0};
  int exp_ferr     = 0;
  int exp_ovf[2]   = '{0, 0};
  logic [18:0] exp_q[2][$];
  logic [7:0]  m_rs = 8'h00;
  bit          m_rs_ok = 0;
  logic [7:0]  m_data[$];

  function automatic logic [18:0] pack(input logic on, input logic [3:0] ch,
                                       input logic [6:0] n, input logic [6:0] v);
    return {on, ch, n, v};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_push(input int k, input logic [18:0] e);
    if (exp_q[k].size() >= DEPTH) exp_ovf[k]++;
    else exp_q[k].push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [18:0] e;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin m_rs_ok = 0; m_data.delete(); return; end
    if (b >= 8'h80) begin m_rs = b; m_rs_ok = 1; m_data.delete(); return; end
    if (!m_rs_ok) return;
    m_data.push_back(b);
    if (m_data.size() < ((m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2)) return;
    if (m_rs[7:4] == 4'h8 || m_rs[7:4] == 4'h9) begin
      e = pack(m_rs[7:4] == 4'h9 && m_data[1] != 8'h00, m_rs[3:0], m_data[0][6:0], m_data[1][6:0]);
      model_push(0, e);
      if (m_rs[3:0] == 4'd2) model_push(1, e);
    end
    m_data.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    midi = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      midi = b[i];
      tick(CPB);
    end
    midi = stop_ok;
    if (stop_ok) model_byte(b);
    else begin exp_ferr++; m_data.delete(); end
    tick(CPB);
    midi = 1'b1;
    tick(4);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 1); send_byte(b, 1); send_byte(c, 1);
  endtask

  task automatic check_state(input string tag);
    tick(4);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s count%0d", tag, k), 32'(cnt[k]), 32'(exp_q[k].size()));
      chk($sformatf("%s valid%0d", tag, k), 32'(valid[k]), 32'(exp_q[k].size() != 0));
      chk($sformatf("%s ferr%0d", tag, k), ferr_seen[k], exp_ferr);
      chk($sformatf("%s ovf%0d", tag, k), ovf_seen[k], exp_ovf[k]);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    ready = 1'b1;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || valid[0] || valid[1]) && n < 100) begin
      tick(1);
      n++;
    end
    ready = 1'b0;
    chk({tag, " drain_bound"}, 32'(n < 100), 32'd1);
    check_state(tag);
  endtask

  // Pulse counting and per-pop comparison of the FIFO head against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (ferr[k]) ferr_seen[k]++;
        if (ovf[k])  ovf_seen[k]++;
        if (valid[k] && ready) begin
          checks++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL pop%0d: got event %h expected none", k, head[k]);
          end else begin
            if (head[k] !== exp_q[k][0]) begin
              errors++;
              $display("FAIL pop%0d: got %h expected %h", k, head[k], exp_q[k][0]);
            end
            void'(exp_q[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("rst rx_led", 32'(rx_led_a), 32'd0);
    chk("rst valid", 32'(valid[0]), 32'd0);
    chk("rst count", 32'(cnt[0]), 32'd0);
    chk("rst head", 32'(head[0]), 32'd0);
    chk("rst ferr", 32'(ferr[0]), 32'd0);
    chk("rst ovf", 32'(ovf[1]), 32'd0);
    rst = 1'b0;
    tick(3);

    // single Note On, omni instance only
    send3(8'h90, 8'h3C, 8'h64);
    check_state("t1");
    chk("t1 head", 32'(head[0]), 32'(pack(1'b1, 4'h0, 7'h3C, 7'h64)));
    chk("t1 model", 32'(exp_q[0][0]), 32'(pack(1'b1, 4'h0, 7'h3C, 7'h64)));
    chk("t1 filtered", 32'(cnt[1]), 32'd0);
    drain("t1");

    // running status, vel 0 -> Note Off
    send3(8'h91, 8'h40, 8'h50);
    send_byte(8'h40, 1); send_byte(8'h00, 1);
    check_state("t2");
    chk("t2 count", 32'(cnt[0]), 32'd2);
    chk("t2 model off", 32'(exp_q[0][1]), 32'(pack(1'b0, 4'h1, 7'h40, 7'h00)));
    drain("t2");

    // realtime byte between data bytes; system status kills running status
    send_byte(8'h90, 1); send_byte(8'h3C, 1); send_byte(8'hF8, 1); send_byte(8'h64, 1);
    check_state("t3");
    chk("t3 head", 32'(head[0]), 32'(pack(1'b1, 4'h0, 7'h3C, 7'h64)));
    drain("t3");
    send3(8'hF0, 8'h10, 8'h20);
    send3(8'hC2, 8'h05, 8'h06);
    check_state("t3b");

    // overflow on channel 2: both instances fill and drop one
    send_byte(8'h92, 1);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h10 + 8'(i), 1); send_byte(8'h20, 1);
    end
    check_state("t4");
    chk("t4 count", 32'(cnt[0]), 32'd4);
    chk("t4 ovf", ovf_seen[1], 32'd1);
    drain("t4");

    // framing error on velocity byte, running status survives
    send_byte(8'h90, 1); send_byte(8'h3C, 1); send_byte(8'h64, 0);
    check_state("t5a");
    chk("t5 ferr", ferr_seen[0], 32'd1);
    send_byte(8'h3D, 1); send_byte(8'h65, 1);
    check_state("t5b");
    chk("t5 head", 32'(head[0]), 32'(pack(1'b1, 4'h0, 7'h3D, 7'h65)));
    drain("t5");

    // channel filter
    send3(8'h93, 8'h30, 8'h10);
    check_state("t6a");
    chk("t6 ch3 filtered", 32'(cnt[1]), 32'd0);
    send3(8'h92, 8'h30, 8'h10);
    check_state("t6b");
    chk("t6 ch2 head", 32'(head[1]), 32'(pack(1'b1, 4'h2, 7'h30, 7'h10)));

    // reset in the middle of a byte, with events queued
    midi = 1'b0;
    tick(40);
    chk("t7 rx_led", 32'(rx_led_a), 32'd1);
    rst = 1'b1;
    exp_q[0].delete(); exp_q[1].delete(); m_rs_ok = 0; m_data.delete();
    tick(2);
    chk("t7 count a", 32'(cnt[0]), 32'd0);
    chk("t7 count b", 32'(cnt[1]), 32'd0);
    chk("t7 valid", 32'(valid[1]), 32'd0);
    midi = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    send_byte(8'h30, 1); send_byte(8'h10, 1);
    check_state("t7a");
    send3(8'h92, 8'h31, 8'h11);
    check_state("t7b");
    drain("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
